// File: rtl/pad_out_arbiter.sv
// rtl/pad_out_arbiter.sv - round-robin arbiter framing one requester word at a time onto 8 output pads
module pad_out_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int NUM_OUTPUT_PADS = 8,
    parameter int HOLD_CYCLES     = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_OUTPUT_PADS-1:0] output_out,
    output logic                       busy,
    output logic [3:0]                 grant_id
);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
            $error("pad_out_arbiter: NUM_REQ must be 2..16");
        end
        if (NUM_OUTPUT_PADS != 8) begin : g_bad_pads
            $error("pad_out_arbiter: NUM_OUTPUT_PADS must be 8");
        end
        if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
            $error("pad_out_arbiter: HOLD_CYCLES must be 1..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_DATA,
        S_GAP
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] rr_ptr, rr_ptr_nxt;
    logic [3:0] grant_q, grant_nxt;
    logic [7:0] word_q, word_nxt;
    logic [7:0] cnt_q, cnt_nxt;
    logic [7:0] out_q, out_nxt;
    logic       busy_q, busy_nxt;

    logic       found_hi, found_any;
    logic [3:0] hi_idx, lo_idx, win_idx;
    logic [7:0] win_word;
    logic       accept;

    // Two-pass search: first valid at or above rr_ptr, otherwise lowest valid (wrap).
    always_comb begin
        found_hi  = 1'b0;
        found_any = 1'b0;
        hi_idx    = 4'd0;
        lo_idx    = 4'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_hi && req_valid[i] && (4'(i) >= rr_ptr)) begin
                found_hi = 1'b1;
                hi_idx   = 4'(i);
            end
            if (!found_any && req_valid[i]) begin
                found_any = 1'b1;
                lo_idx    = 4'(i);
            end
        end
        win_idx = found_hi ? hi_idx : lo_idx;
    end

    assign accept = (state == S_IDLE) && found_any;

    always_comb begin
        req_ready = '0;
        win_word  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && rst_n && (win_idx == 4'(i));
            if (win_idx == 4'(i)) begin
                win_word = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        grant_nxt  = grant_q;
        word_nxt   = word_q;
        cnt_nxt    = cnt_q;
        out_nxt    = out_q;
        busy_nxt   = busy_q;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt  = S_HEADER;
                    grant_nxt  = win_idx;
                    word_nxt   = win_word;
                    rr_ptr_nxt = (win_idx == 4'(NUM_REQ - 1)) ? 4'd0 : win_idx + 4'd1;
                    out_nxt    = 8'hA0 | {4'h0, win_idx};
                    busy_nxt   = 1'b1;
                end
            end
            S_HEADER: begin
                state_nxt = S_DATA;
                out_nxt   = word_q;
                cnt_nxt   = 8'(HOLD_CYCLES);
            end
            S_DATA: begin
                if (cnt_q == 8'd1) begin
                    state_nxt = S_GAP;
                    out_nxt   = 8'h00;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt_q - 8'd1;
                end
            end
            S_GAP: begin
                state_nxt = S_IDLE;
                out_nxt   = 8'h00;
                busy_nxt  = 1'b0;
                grant_nxt = 4'd0;
            end
            default: begin
                state_nxt = S_IDLE;
                out_nxt   = 8'h00;
                busy_nxt  = 1'b0;
                grant_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            rr_ptr  <= 4'd0;
            grant_q <= 4'd0;
            word_q  <= 8'h00;
            cnt_q   <= 8'd0;
            out_q   <= 8'h00;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            rr_ptr  <= rr_ptr_nxt;
            grant_q <= grant_nxt;
            word_q  <= word_nxt;
            cnt_q   <= cnt_nxt;
            out_q   <= out_nxt;
            busy_q  <= busy_nxt;
        end
    end

    assign output_out = out_q;
    assign busy       = busy_q;
    assign grant_id   = grant_q;

endmodule

// File: tb/tb_pad_out_arbiter.sv
// tb/tb_pad_out_arbiter.sv - directed self-checking bench for pad_out_arbiter
module tb_pad_out_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready, ready_h1, ready_h255;
    logic [7:0]  output_out, out_h1, out_h255;
    logic        busy, busy_h1, busy_h255;
    logic [3:0]  grant_id, grant_h1, grant_h255;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pad_out_arbiter #(.NUM_REQ(4), .NUM_OUTPUT_PADS(8), .HOLD_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .output_out(output_out), .busy(busy), .grant_id(grant_id)
    );

    pad_out_arbiter #(.NUM_REQ(4), .NUM_OUTPUT_PADS(8), .HOLD_CYCLES(1)) u_h1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(ready_h1), .output_out(out_h1), .busy(busy_h1), .grant_id(grant_h1)
    );

    pad_out_arbiter #(.NUM_REQ(4), .NUM_OUTPUT_PADS(8), .HOLD_CYCLES(255)) u_h255 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(ready_h255), .output_out(out_h255), .busy(busy_h255), .grant_id(grant_h255)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Starts in an IDLE cycle with inputs applied; ends in the IDLE cycle after GAP.
    task automatic run_frame(input int id, input logic [7:0] d, input bit clobber);
        chk("ready_win", 32'(req_ready), 32'(4'b0001 << id));
        cyc();
        if (clobber) begin
            req_valid = '0;
            req_data  = '0;
        end
        chk("hdr_out", 32'(output_out), 32'(8'hA0 | 8'(id)));
        chk("hdr_busy", 32'(busy), 32'd1);
        chk("hdr_grant", 32'(grant_id), 32'(id));
        chk("hdr_ready", 32'(req_ready), 32'd0);
        repeat (2) begin
            cyc();
            chk("data_out", 32'(output_out), 32'(d));
            chk("data_busy", 32'(busy), 32'd1);
        end
        cyc();
        chk("gap_out", 32'(output_out), 32'h00);
        chk("gap_busy", 32'(busy), 32'd1);
        cyc();
        chk("idle_out", 32'(output_out), 32'h00);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_grant", 32'(grant_id), 32'd0);
    endtask

    initial begin
        int n2, n1, n255;

        // Reset state, with requests pending that must not be acknowledged
        req_valid = 4'b1111;
        req_data  = 32'h44332211;
        #12;
        chk("rst_out", 32'(output_out), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);

        // Single request, word changed after accept
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b0100;
        req_data  = 32'h005C0000;
        #1;
        run_frame(2, 8'h5C, 1'b1);

        // Pointer wrap: rr_ptr is 3, so 3 then 0 then 3
        req_valid = 4'b1001;
        req_data  = 32'h93000010;
        #1;
        run_frame(3, 8'h93, 1'b0);
        run_frame(0, 8'h10, 1'b0);
        run_frame(3, 8'h93, 1'b1);

        // Data clobbered right after accept must not reach the pads
        req_valid = 4'b0010;
        req_data  = 32'h00007E00;
        #1;
        run_frame(1, 8'h7E, 1'b1);

        // Lone requester is granted on every opportunity
        req_valid = 4'b0100;
        req_data  = 32'h00C70000;
        #1;
        run_frame(2, 8'hC7, 1'b0);
        run_frame(2, 8'hC7, 1'b0);

        // Reset in DATA aborts the frame; rr_ptr (3 here) returns to 0
        chk("mid_ready", 32'(req_ready), 32'h4);
        cyc();
        req_valid = '0;
        chk("mid_hdr", 32'(output_out), 32'hA2);
        cyc();
        chk("mid_data", 32'(output_out), 32'hC7);
        #2;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("async_out", 32'(output_out), 32'h00);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_grant", 32'(grant_id), 32'd0);
        chk("async_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b1010;
        req_data  = 32'h77005500;
        #1;
        run_frame(1, 8'h55, 1'b1);

        // All valid from reset: grants cycle 0,1,2,3,0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        req_data  = 32'h44332211;
        #1;
        for (int k = 0; k < 5; k++) begin
            run_frame(k % 4, 8'((k % 4 + 1) * 8'h11), 1'b0);
        end
        req_valid = '0;

        // DATA phase length for HOLD_CYCLES 2, 1, 255
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b0001;
        req_data  = 32'h0000003C;
        #1;
        chk("h1_ready", 32'(ready_h1), 32'h1);
        chk("h255_ready", 32'(ready_h255), 32'h1);
        cyc();
        req_valid = '0;
        chk("h255_hdr", 32'(out_h255), 32'hA0);
        n2 = 0;
        n1 = 0;
        n255 = 0;
        for (int c = 0; c < 300; c++) begin
            if (busy && output_out == 8'h3C) n2++;
            if (busy_h1 && out_h1 == 8'h3C) n1++;
            if (busy_h255 && out_h255 == 8'h3C) n255++;
            cyc();
        end
        chk("hold2_len", 32'(n2), 32'd2);
        chk("hold1_len", 32'(n1), 32'd1);
        chk("hold255_len", 32'(n255), 32'd255);
        chk("hold255_idle", 32'(busy_h255), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pad_out_arbiter.md
PAD_OUT_ARBITER -- requirements
Module: pad_out_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the output pads; legal range 2..16.
REQ-002 Parameter NUM_OUTPUT_PADS, default 8: output pad bus width; fixed at 8, any other value is a configuration error.
REQ-003 Parameter HOLD_CYCLES, default 2: cycles each data word is held on the pads; legal range 1..255.
REQ-004 clk  input  1  single clock for all state.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester word-pending flag; bit i belongs to requester i.
REQ-007 req_data  input  NUM_REQ*8  per-requester word; requester i at bits [8*i+7:8*i].
REQ-008 req_ready  output  NUM_REQ  one-hot acceptance strobe; bit i high means requester i's word is taken at this clock edge.
REQ-009 output_out  output  NUM_OUTPUT_PADS  registered value driven to the output pads.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 grant_id  output  4  index of the requester currently being transmitted; 0 when IDLE.

Function
REQ-012 The block SHALL implement FSM states IDLE, HEADER, DATA, GAP; all outputs except req_ready are registered.
REQ-013 In IDLE, output_out SHALL be 8'h00, busy 0, grant_id 0.
REQ-014 In IDLE with any req_valid high, the winner SHALL be the first valid requester searching upward from rr_ptr, wrapping NUM_REQ-1 -> 0.
REQ-015 req_ready SHALL be combinational, high only for the winner and only while state is IDLE; all bits 0 in every other state.
REQ-016 At the acceptance edge the block SHALL capture the winner's req_data and index, set rr_ptr to (winner+1) mod NUM_REQ, and enter HEADER.
REQ-017 In HEADER (exactly 1 cycle), output_out SHALL be 8'hA0 | grant_id, i.e. 0xA0..0xAF.
REQ-018 From HEADER the FSM SHALL enter DATA with output_out = captured word, held for exactly HOLD_CYCLES cycles via a down-counter.
REQ-019 After the last DATA cycle the FSM SHALL enter GAP (exactly 1 cycle, output_out = 8'h00), then IDLE.
REQ-020 Frame length SHALL be HOLD_CYCLES+2 cycles; the earliest next acceptance is the first IDLE cycle after GAP, so back-to-back frames are separated by at least one IDLE cycle.
REQ-021 Changes to req_valid/req_data after acceptance SHALL NOT affect the frame in progress.
REQ-022 A requester whose req_valid drops before being granted SHALL be skipped without side effects; rr_ptr changes only on acceptance.
REQ-023 With a single requester continuously valid, it SHALL be granted on every IDLE opportunity (no starvation of a lone requester by the pointer).
REQ-024 With all requesters continuously valid, grants SHALL cycle 0,1,...,NUM_REQ-1,0,... from reset.

Reset
REQ-025 rst_n low SHALL immediately, without waiting for clk, force state IDLE, output_out 8'h00, busy 0, grant_id 0, rr_ptr 0, counter 0, captured word 0; req_ready SHALL be all 0 while rst_n is low.
REQ-026 Reset asserted mid-frame SHALL abort the frame; the aborted word is not retransmitted.
REQ-027 After rst_n deasserts, the first acceptance SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-028 Single request: req_valid=4'b0100, data[2]=0x5C, HOLD_CYCLES=2 -> req_ready=4'b0100 one cycle; output_out sequence 0xA2, 0x5C, 0x5C, 0x00, then 0x00 idle; busy high 4 cycles.
REQ-029 All valid, distinct data 0x11/0x22/0x33/0x44 held constant -> headers in order 0xA0, 0xA1, 0xA2, 0xA3, 0xA0; each data word appears HOLD_CYCLES cycles.
REQ-030 Pointer wrap: grant 3 first, then req_valid=4'b1001 -> next header 0xA0, then 0xA3.
REQ-031 Data change after accept: data[1] changes 0x7E->0x00 the cycle after req_ready[1] -> pads still show 0x7E for the full DATA phase.
REQ-032 Reset in DATA phase: rst_n low mid-hold -> output_out 0x00, busy 0 before next clk edge; after release with req_valid=4'b0010 -> header 0xA1 (rr_ptr restarted at 0).
REQ-033 HOLD_CYCLES=1 and HOLD_CYCLES=255 builds -> DATA phase lasts exactly 1 and 255 cycles respectively.
